bldc_hall_emulator: RTL and testbench
=====================================

// Module: bldc_hall_emulator
// PURPOSE
//  Closed-loop BLDC motor/hall-sensor model: the far end of the commutation interface.
//  Consumes the controller's six gate-drive outputs and produces 120-degree hall signals.
//  The rotor advances only when it is driven with the correct pattern for its sector.
//  Used in benches and as an on-chip self-test loopback for the BLDC controller.
// PARAMETERS
//  PERIOD_W  16  width of step_period (cycles per 60-degree sector)
//  REV_W     8   width of revolution counter
// PORTS
//  clk          in   1         single clock
//  rst          in   1         synchronous reset, active-high
//  en           in   1         model enable; 0 freezes all state
//  dir          in   1         0 = forward, 1 = reverse
//  step_period  in   PERIOD_W  cycles per sector; 0 treated as 1
//  gate         in   6         {AH,AL,BH,BL,CH,CL} from controller
//  fault_clr    in   1         clears sticky faults
//  hall         out  3         {HA,HB,HC}, registered
//  sector       out  3         current sector 0..5, registered
//  step_pulse   out  1         1-cycle pulse on each sector advance
//  rev_count    out  REV_W     electrical revolutions, wraps mod 2^REV_W
//  shoot_fault  out  1         sticky: any phase with H and L both high
//  comm_err     out  1         sticky: non-zero drive not matching sector
// BEHAVIOUR
//  Reset: sector=0, hall=3'b101, timer=0, step_pulse=0, rev_count=0, both faults=0.
//  Hall table, sector 0..5: 101,100,110,010,011,001.
//  Forward expected drive per sector: 0:AH+BL 1:AH+CL 2:BH+CL 3:BH+AL 4:CH+AL 5:CH+BL.
//  Reverse (dir=1): the same table with H/L swapped on each phase (0:AL+BH, ...).
//  Per cycle with en=1, classify gate (priority order):
//   - shoot-through (any xH&xL): shoot_fault<=1; timer and sector hold.
//   - gate==0 (coast): timer and sector hold; no error.
//   - gate==expected(sector,dir): timer advances.
//   - any other gate value: comm_err<=1; timer and sector hold.
//  Advance:
//   - When timer>=eff_period-1 with matching drive: timer<=0, sector<=sector+/-1 mod 6,
//     hall<=table[next], step_pulse<=1, all on that same edge.
//   - Steady matching drive gives one hall change every eff_period cycles.
//   - eff_period=1 gives an advance every cycle.
//  rev_count +1 on each 5->0 (forward) or 0->5 (reverse) transition.
//  dir change mid-step: timer is kept; expected pattern is re-evaluated in the same cycle.
//  step_period lowered below timer: advance on the next matching cycle.
//  en=0: all registers hold; step_pulse=0.
//  fault_clr and a new fault in the same cycle: set wins.
//  rst mid-step: returns to reset state on that edge, overriding everything.
// STRUCTURE
//  bldc_pkg: HALL_TABLE[6], sector typedef (3-bit), gate bit-index constants,
//   function expected_drive(sector,dir) -> 6-bit pattern.
//  Sub-module bldc_step_timer: PERIOD_W counter with hold/clear/terminal-count output.
//  Top: classify logic, sector/hall registers, revolution counter, fault flags.
// TESTING
//  1. Reset, period=4, fwd drive tracking sector -> hall 101,100,110,010,011,001,101 every 4 clk;
//     rev_count=1 after 24 clk.
//  2. dir=1 with swapped patterns, period=2 -> sector 0,5,4,..; rev_count=1 on the 0->5 step.
//  3. gate=6'b110000 (AH+AL) -> shoot_fault=1 next edge, hall frozen; fault_clr -> 0.
//  4. Sector 0 driven with AH+CL -> comm_err=1, no advance; gate=0 -> holds, no new error.
//  5. step_period=0 -> advance every cycle; en=0 mid-run -> hall/timer frozen, step_pulse=0.
//  6. rst asserted at timer=2 of period 8 -> hall=101, sector=0, rev_count=0 on next edge.

Source files
------------

// File: rtl/bldc_pkg.sv
// bldc_pkg: hall table, sector type, gate bit positions and expected-drive lookup
package bldc_pkg;
  typedef logic [2:0] sector_t;
  localparam int AH = 5;
  localparam int AL = 4;
  localparam int BH = 3;
  localparam int BL = 2;
  localparam int CH = 1;
  localparam int CL = 0;
  localparam logic [2:0] HALL_TABLE [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  localparam logic [5:0] FWD_DRIVE [6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
  // reverse rotation uses the forward pattern with each phase's high/low legs swapped
  function automatic logic [5:0] expected_drive(sector_t s, logic dir);
    logic [5:0] f;
    f = FWD_DRIVE[s];
    return dir ? {f[AL], f[AH], f[BL], f[BH], f[CL], f[CH]} : f;
  endfunction
endpackage

// File: rtl/bldc_step_timer.sv
// bldc_step_timer: per-sector cycle counter that holds unless run, wraps at terminal count
module bldc_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tc
);
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] last;
  // a zero period behaves as one; >= lets a lowered period fire on the next run cycle
  assign last = period == '0 ? '0 : period - PERIOD_W'(1);
  assign tc = count >= last;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (run) count <= tc ? '0 : count + PERIOD_W'(1);
endmodule

// File: rtl/bldc_hall_emulator.sv
// bldc_hall_emulator: rotor/hall model that advances only under correct commutation drive
module bldc_hall_emulator
  import bldc_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int REV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic [5:0]          gate,
  input  logic                fault_clr,
  output logic [2:0]          hall,
  output logic [2:0]          sector,
  output logic                step_pulse,
  output logic [REV_W-1:0]    rev_count,
  output logic                shoot_fault,
  output logic                comm_err
);
  logic shoot, match, bad, tc, adv, wrap;
  sector_t nxt;
  always_comb begin
    shoot = (gate[AH] & gate[AL]) | (gate[BH] & gate[BL]) | (gate[CH] & gate[CL]);
    match = !shoot && gate == expected_drive(sector, dir);
    bad = !shoot && gate != '0 && !match;
    adv = en && match && tc;
    wrap = dir ? sector == 3'd0 : sector == 3'd5;
    nxt = dir ? (sector == 3'd0 ? 3'd5 : sector - 3'd1) : (sector == 3'd5 ? 3'd0 : sector + 3'd1);
  end
  bldc_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(en && match),
    .period(step_period),
    .tc(tc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      sector <= 3'd0;
      hall <= HALL_TABLE[0];
      step_pulse <= 1'b0;
      rev_count <= '0;
      shoot_fault <= 1'b0;
      comm_err <= 1'b0;
    end else if (en) begin
      step_pulse <= adv;
      if (adv) begin
        sector <= nxt;
        hall <= HALL_TABLE[nxt];
        if (wrap) rev_count <= rev_count + REV_W'(1);
      end
      shoot_fault <= shoot | (shoot_fault & ~fault_clr);
      comm_err <= bad | (comm_err & ~fault_clr);
    end else step_pulse <= 1'b0;
endmodule

// File: tb/tb_bldc_hall_emulator.sv
// tb_bldc_hall_emulator: directed and random scenarios against a phase-level rotor model
module tb_bldc_hall_emulator;
  logic clk = 0, rst = 1, en = 1, dir = 0, fault_clr = 0;
  logic [15:0] step_period = 16'd4;
  logic [5:0] gate = '0;
  logic [2:0] hall, sector;
  logic step_pulse, shoot_fault, comm_err;
  logic [7:0] rev_count;
  int vectors = 0, miscompares = 0;
  int m_sector, m_timer, m_rev;
  bit m_pulse, m_shoot, m_comm;
  int HALL [6] = '{5, 4, 6, 2, 3, 1};
  int HI [6] = '{0, 0, 1, 1, 2, 2};
  int LO [6] = '{1, 2, 2, 0, 0, 1};
  wire [16:0] dut_vec = {hall, sector, step_pulse, rev_count, shoot_fault, comm_err};

  bldc_hall_emulator dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step_period(step_period), .gate(gate),
    .fault_clr(fault_clr), .hall(hall), .sector(sector), .step_pulse(step_pulse),
    .rev_count(rev_count), .shoot_fault(shoot_fault), .comm_err(comm_err)
  );

  always #5 clk = ~clk;

  // phase 0=A,1=B,2=C; reverse sources current from the opposite legs
  function automatic logic [5:0] drive_of(int s, bit d);
    int h, l;
    h = d ? LO[s] : HI[s];
    l = d ? HI[s] : LO[s];
    return (6'b1 << (5 - 2 * h)) | (6'b1 << (4 - 2 * l));
  endfunction

  function automatic logic [16:0] exp_vec();
    return {3'(HALL[m_sector]), 3'(m_sector), m_pulse, 8'(m_rev), m_shoot, m_comm};
  endfunction

  task automatic model_step();
    bit any_shoot, new_comm;
    int eff;
    if (rst) begin
      m_sector = 0; m_timer = 0; m_rev = 0; m_pulse = 0; m_shoot = 0; m_comm = 0;
      return;
    end
    if (!en) begin
      m_pulse = 0;
      return;
    end
    any_shoot = 0;
    for (int p = 0; p < 3; p++) if (gate[5 - 2 * p] && gate[4 - 2 * p]) any_shoot = 1;
    new_comm = 0;
    m_pulse = 0;
    eff = step_period == 0 ? 1 : int'(step_period);
    if (!any_shoot && gate != 0) begin
      if (gate == drive_of(m_sector, dir)) begin
        if (m_timer >= eff - 1) begin
          m_timer = 0;
          m_pulse = 1;
          if (!dir && m_sector == 5) m_rev++;
          if (dir && m_sector == 0) m_rev++;
          m_sector = dir ? (m_sector + 5) % 6 : (m_sector + 1) % 6;
        end else m_timer++;
      end else new_comm = 1;
    end
    m_shoot = any_shoot || (m_shoot && !fault_clr);
    m_comm = new_comm || (m_comm && !fault_clr);
  endtask

  task automatic cycle(input logic [5:0] g);
    gate = g;
    model_step();
    @(posedge clk);
    #1;
    vectors++;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; dir = 0; fault_clr = 0; step_period = 16'd4;
    cycle(6'b0);
    if (dut_vec !== exp_vec() || hall !== 3'b101) begin
      miscompares++;
      $display("FAIL reset: got %b exp %b", dut_vec, exp_vec());
    end
    rst = 0;
  endtask

  task automatic test_forward();
    for (int i = 0; i < 24; i++) begin
      cycle(drive_of(m_sector, 0));
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL forward[%0d]: got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    if (rev_count !== 8'd1 || hall !== 3'b101 || sector !== 3'd0) begin
      miscompares++;
      $display("FAIL forward_rev: rev %0d hall %b sector %0d exp 1 101 0", rev_count, hall, sector);
    end
  endtask

  task automatic test_reverse();
    test_reset();
    dir = 1; step_period = 16'd2;
    for (int i = 0; i < 12; i++) begin
      cycle(drive_of(m_sector, 1));
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL reverse[%0d]: got %b exp %b", i, dut_vec, exp_vec());
      end
      if (i == 1 && (sector !== 3'd5 || rev_count !== 8'd1 || hall !== 3'b001)) begin
        miscompares++;
        $display("FAIL reverse_wrap: sector %0d rev %0d hall %b exp 5 1 001", sector, rev_count, hall);
      end
    end
    dir = 0;
  endtask

  task automatic test_shoot();
    logic [2:0] h0;
    h0 = hall;
    cycle(6'b110000);
    if (dut_vec !== exp_vec() || shoot_fault !== 1'b1 || hall !== h0) begin
      miscompares++;
      $display("FAIL shoot_set: got %b exp %b", dut_vec, exp_vec());
    end
    fault_clr = 1;
    cycle(6'b0);
    fault_clr = 0;
    if (dut_vec !== exp_vec() || shoot_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL shoot_clr: got %b exp %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_comm();
    test_reset();
    cycle(6'b100001);
    if (dut_vec !== exp_vec() || comm_err !== 1'b1 || sector !== 3'd0) begin
      miscompares++;
      $display("FAIL comm_set: got %b exp %b", dut_vec, exp_vec());
    end
    fault_clr = 1;
    cycle(6'b0);
    fault_clr = 0;
    repeat (3) begin
      cycle(6'b0);
      if (dut_vec !== exp_vec() || comm_err !== 1'b0 || sector !== 3'd0) begin
        miscompares++;
        $display("FAIL coast_hold: got %b exp %b", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_fast_en();
    logic [2:0] h0;
    step_period = 16'd0;
    for (int i = 0; i < 8; i++) begin
      cycle(drive_of(m_sector, 0));
      if (dut_vec !== exp_vec() || step_pulse !== 1'b1) begin
        miscompares++;
        $display("FAIL fast[%0d]: got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    en = 0;
    h0 = hall;
    repeat (4) begin
      cycle(drive_of(m_sector, 0));
      if (dut_vec !== exp_vec() || hall !== h0 || step_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL en_freeze: got %b exp %b", dut_vec, exp_vec());
      end
    end
    en = 1;
    cycle(drive_of(m_sector, 0));
    if (dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL en_resume: got %b exp %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_rst_mid();
    step_period = 16'd8;
    repeat (2) cycle(drive_of(m_sector, 0));
    rst = 1;
    cycle(drive_of(m_sector, 0));
    rst = 0;
    if (dut_vec !== exp_vec() || hall !== 3'b101 || sector !== 3'd0 || rev_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got %b exp %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [5:0] g;
    int r;
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) == 0;
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 7) == 0) step_period = 16'($urandom_range(0, 5));
      fault_clr = $urandom_range(0, 9) == 0;
      r = $urandom_range(0, 99);
      g = r < 65 ? drive_of(m_sector, dir) : r < 80 ? 6'b0 : 6'($urandom);
      cycle(g);
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    rst = 0; en = 1; fault_clr = 0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_shoot();
    test_comm();
    test_fast_en();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
